// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM state codes, DMType
// access-size codes, parameter defaults and the timeout fill pattern.
package mem_port_arbiter_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BUSY_I = 3'd1;
  localparam logic [2:0] ST_BUSY_D = 3'd2;
  localparam logic [2:0] ST_RESP_I = 3'd3;
  localparam logic [2:0] ST_RESP_D = 3'd4;

  // DMType access-size/sign codes
  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 15;

  // Read data returned with an error completion
  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// arb_timeout_ctr: loadable cycle counter for the BUSY timeout.
//   clk_i      clock
//   reset_i    synchronous active-high reset
//   load_i     restart the count at zero
//   en_i       count this cycle (one BUSY cycle)
//   expired_o  this enabled cycle is the LIMIT-th one
module arb_timeout_ctr #(
  parameter int LIMIT = 15,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of BUSY cycles already completed, so the
  // current cycle is the LIMIT-th when cnt_q == LIMIT-1.
  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                              cnt_d = '0;
    else if (en_i && cnt_q != CW'(LIMIT))    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch (if_*)
// and data (d_*) ports, one outstanding access at a time. Data has priority,
// a starvation counter forces a fetch grant after STARVE_MAX consecutive data
// grants, and an access with no mem_ack for TIMEOUT BUSY cycles completes
// with an error and rdata = 0xDEADBEEF. All outputs are registered.
//   clk_i/reset_i         clock, synchronous active-high reset
//   if_req_i/if_addr_i    fetch request in; if_rdata_o/if_ready_o/if_err_o out
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_dmtype_i  data request in
//   d_rdata_o/d_ready_o/d_err_o                    data completion out
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_dmtype_o  memory request
//   mem_rdata_i/mem_ack_i  memory response
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ready_o,
  output logic          if_err_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  input  logic [2:0]    d_dmtype_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ready_o,
  output logic          d_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [2:0]    mem_dmtype_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mreq_q, mreq_d, mwe_q, mwe_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic [2:0]    mdm_q, mdm_d;
  logic [DW-1:0] irdata_q, irdata_d, drdata_q, drdata_d;
  logic          irdy_q, irdy_d, ierr_q, ierr_d;
  logic          drdy_q, drdy_d, derr_q, derr_d;

  logic busy, expired, give_d;

  assign busy = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

  arb_timeout_ctr #(.LIMIT(TIMEOUT)) u_tmo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (!busy),
    .en_i      (busy),
    .expired_o (expired)
  );

  // Data wins unless fetch is waiting and has been passed over STARVE_MAX times
  assign give_d = d_req_i && !(if_req_i && starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mdm_d    = mdm_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    irdy_d   = irdy_q;
    ierr_d   = ierr_q;
    drdy_d   = drdy_q;
    derr_d   = derr_q;
    case (state_q)
      ST_IDLE: begin
        if (give_d) begin
          mreq_d   = 1'b1;
          mwe_d    = d_we_i;
          maddr_d  = d_addr_i;
          mwdata_d = d_wdata_i;
          mdm_d    = d_dmtype_i;
          state_d  = ST_BUSY_D;
          if (!if_req_i)                          starve_d = '0;
          else if (starve_q != SW'(STARVE_MAX))   starve_d = starve_q + 1'b1;
        end else if (if_req_i) begin
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = if_addr_i;
          mdm_d    = DM_WORD;
          state_d  = ST_BUSY_I;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // An ack on the expiry cycle still counts as a normal completion
        if (mem_ack_i || expired) begin
          mreq_d = 1'b0;
          if (state_q == ST_BUSY_I) begin
            state_d  = ST_RESP_I;
            irdy_d   = 1'b1;
            ierr_d   = !mem_ack_i;
            irdata_d = mem_ack_i ? mem_rdata_i : DW'(ERR_RDATA);
          end else begin
            state_d = ST_RESP_D;
            drdy_d  = 1'b1;
            derr_d  = !mem_ack_i;
            if (!mem_ack_i)   drdata_d = DW'(ERR_RDATA);
            else if (!mwe_q)  drdata_d = mem_rdata_i;
          end
        end
      end
      ST_RESP_I, ST_RESP_D: begin
        irdy_d  = 1'b0;
        ierr_d  = 1'b0;
        drdy_d  = 1'b0;
        derr_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mdm_q    <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      irdy_q   <= 1'b0;
      ierr_q   <= 1'b0;
      drdy_q   <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mdm_q    <= mdm_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      irdy_q   <= irdy_d;
      ierr_q   <= ierr_d;
      drdy_q   <= drdy_d;
      derr_q   <= derr_d;
    end
  end

  assign mem_req_o    = mreq_q;
  assign mem_we_o     = mwe_q;
  assign mem_addr_o   = maddr_q;
  assign mem_wdata_o  = mwdata_q;
  assign mem_dmtype_o = mdm_q;
  assign if_rdata_o   = irdata_q;
  assign if_ready_o   = irdy_q;
  assign if_err_o     = ierr_q;
  assign d_rdata_o    = drdata_q;
  assign d_ready_o    = drdy_q;
  assign d_err_o      = derr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SM  = 4;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          if_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [2:0]    d_dmtype = '0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic          if_ready, if_err, d_ready, d_err, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_dmtype;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .reset_i(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
    .if_ready_o(if_ready), .if_err_o(if_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_dmtype_i(d_dmtype), .d_rdata_o(d_rdata), .d_ready_o(d_ready), .d_err_o(d_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_dmtype_o(mem_dmtype),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model: one access in flight, described by who owns it,
  // how many BUSY cycles it has consumed, and what it carries.
  int            m_phase = 0;   // 0 idle, 1 waiting on memory, 2 responding
  int            m_who = 0;     // 0 fetch, 1 data
  int            m_busy = 0, m_starve = 0;
  logic          m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [2:0]    m_dm = '0;
  logic          e_mreq = 0, e_irdy = 0, e_ierr = 0, e_drdy = 0, e_derr = 0;
  logic [DW-1:0] e_irdata = '0, e_drdata = '0;

  task automatic model_edge();
    bit to_d, done;
    if (reset) begin
      m_phase = 0; m_starve = 0; m_busy = 0;
      e_mreq = 0; e_irdy = 0; e_ierr = 0; e_drdy = 0; e_derr = 0;
      e_irdata = '0; e_drdata = '0;
      return;
    end
    case (m_phase)
      0: begin
        to_d = d_req && !(if_req && m_starve == SM);
        if (to_d) begin
          m_who = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_dm = d_dmtype;
          m_starve = if_req ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
        end else if (if_req) begin
          m_who = 0; m_we = 0; m_addr = if_addr; m_dm = 3'b000; m_starve = 0;
        end else m_starve = 0;
        if (to_d || if_req) begin m_phase = 1; m_busy = 0; e_mreq = 1; end
      end
      1: begin
        m_busy++;
        done = mem_ack || (m_busy == TMO);
        if (done) begin
          e_mreq = 0; m_phase = 2;
          if (m_who == 0) begin
            e_irdy = 1; e_ierr = !mem_ack;
            e_irdata = mem_ack ? mem_rdata : 32'hDEADBEEF;
          end else begin
            e_drdy = 1; e_derr = !mem_ack;
            if (!mem_ack) e_drdata = 32'hDEADBEEF;
            else if (!m_we) e_drdata = mem_rdata;
          end
        end
      end
      default: begin
        e_irdy = 0; e_ierr = 0; e_drdy = 0; e_derr = 0; m_phase = 0;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    chk("mem_req", mem_req, e_mreq);
    chk("if_ready", if_ready, e_irdy);
    chk("if_err", if_err, e_ierr);
    chk("d_ready", d_ready, e_drdy);
    chk("d_err", d_err, e_derr);
    chk("if_rdata", if_rdata, e_irdata);
    chk("d_rdata", d_rdata, e_drdata);
    if (e_mreq) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_dmtype", mem_dmtype, m_dm);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic quiet(input int n);
    if_req = 0; d_req = 0; mem_ack = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cnt, gcount, ipulses, nack_win;
    bit seen, prev_mreq;
    logic [DW-1:0] held;
    int seq[$];

    // Reset state
    reset = 1; step(); step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    reset = 0; step();

    // Lone load, ack on the first BUSY cycle
    d_req = 1; d_we = 0; d_addr = 32'h100; d_dmtype = 3'b000;
    step();
    chk("load_mreq_c1", mem_req, 1);
    chk("load_addr_c1", mem_addr, 32'h100);
    mem_ack = 1; mem_rdata = 32'h12345678;
    step();
    chk("load_mreq_c2", mem_req, 0);
    chk("load_rdy_c2", d_ready, 1);
    chk("load_rdata_c2", d_rdata, 32'h12345678);
    chk("load_err_c2", d_err, 0);
    d_req = 0; mem_ack = 0;
    step();
    chk("load_rdy_c3", d_ready, 0);
    quiet(2);

    // Store: byte store, rdata must be left alone
    held = d_rdata;
    d_req = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'hCAFEF00D; d_dmtype = 3'b011;
    step();
    chk("st_we", mem_we, 1);
    chk("st_dm", mem_dmtype, 3'b011);
    chk("st_wdata", mem_wdata, 32'hCAFEF00D);
    mem_ack = 1; mem_rdata = 32'h55555555;
    step();
    chk("st_rdy", d_ready, 1);
    chk("st_rdata_kept", d_rdata, held);
    d_req = 0; d_we = 0; mem_ack = 0;
    step();
    chk("st_rdy_once", d_ready, 0);
    quiet(2);

    // Fetch timeout: memory never acks
    if_req = 1; if_addr = 32'h4000;
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (mem_req) cnt++;
      if (if_ready) begin
        seen = 1;
        chk("tmo_err", if_err, 1);
        chk("tmo_rdata", if_rdata, 32'hDEADBEEF);
        chk("tmo_mreq_low", mem_req, 0);
        if_req = 0;
      end
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_busy_cycles", cnt, TMO);
    step();
    chk("tmo_rdy_clear", if_ready, 0);
    chk("tmo_err_clear", if_err, 0);
    quiet(2);

    // Starvation: both held, memory acks every cycle
    if_req = 1; if_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
    mem_ack = 1; prev_mreq = 0; ipulses = 0;
    for (int i = 0; i < 60; i++) begin
      mem_rdata = $urandom;
      step();
      if (mem_req && !prev_mreq) seq.push_back(mem_addr == 32'h1000 ? 0 : 1);
      prev_mreq = mem_req;
      if (if_ready) ipulses++;
    end
    if_req = 0; d_req = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (if_ready) ipulses++;
    end
    mem_ack = 0;
    gcount = seq.size();
    chk("starve_grants", gcount >= 15, 1);
    for (int g = 0; g < gcount; g++)
      chk("starve_order", seq[g], (g % 5 == 4) ? 0 : 1);
    chk("starve_ifrdy", ipulses, gcount / 5);
    quiet(2);

    // Idle ack ignored, then request dropped mid-BUSY
    mem_ack = 1; step(); step();
    chk("idle_ack_rdy", d_ready, 0);
    mem_ack = 0; d_req = 1; d_we = 0; d_addr = 32'h300;
    step();
    d_req = 0; step(); step();
    mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      mem_ack = 0;
      if (d_ready) cnt++;
    end
    chk("drop_rdy_once", cnt, 1);
    quiet(2);

    // Reset mid-BUSY_D
    d_req = 1; d_we = 0; d_addr = 32'h400;
    step(); step();
    reset = 1; step();
    chk("rst_busy_mreq", mem_req, 0);
    chk("rst_busy_rdy", d_ready, 0);
    reset = 0; d_req = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_no_rdy", d_ready, 0);
    end

    // Random traffic
    nack_win = 0;
    for (int i = 0; i < 4000; i++) begin
      if (if_ready) if_req = 0;
      else if (!if_req && $urandom_range(3) == 0) begin if_req = 1; if_addr = $urandom; end
      else if (if_req && $urandom_range(99) == 0) if_req = 0;
      if (d_ready) d_req = 0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_we = $urandom_range(1); d_addr = $urandom;
        d_wdata = $urandom; d_dmtype = 3'($urandom_range(4));
      end else if (d_req && $urandom_range(99) == 0) d_req = 0;
      if (nack_win > 0) begin nack_win--; mem_ack = 0; end
      else begin
        mem_ack = ($urandom_range(2) == 0);
        if ($urandom_range(199) == 0) nack_win = 40;
      end
      mem_rdata = $urandom;
      reset = ($urandom_range(599) == 0);
      step();
    end
    reset = 0;
    quiet(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
